// File: rtl/counter_c_sequencer_pkg.sv
// Shared types and the counter step rule for the parity-stepping counter sequencer.
// The shadow register and the real counter must both use next_count so they stay bit-identical.
package counter_c_pkg;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step by 1 when the current LSB already equals the parity target, else by 2.
  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             f,
    input logic             p
  );
    logic [WIDTH-1:0] delta;
    delta = (cur[0] == p) ? WIDTH'(1) : WIDTH'(2);
    return f ? cur + delta : cur - delta;
  endfunction

endpackage

// File: rtl/counter_c_sequencer_if.sv
// Command bus between the two requesters and the sequencer.
// Handshake: a command for requester i transfers on a rising edge where req_valid[i] & req_ready[i];
// the requester holds valid and its fields stable until then, and may drop valid without side effect.
interface counter_c_sequencer_if
  import counter_c_pkg::*;
#(
  parameter int STEP_W = counter_c_pkg::STEP_W
);

  logic [1:0]          req_valid;
  logic [1:0]          req_dir;
  logic [1:0]          req_par;
  logic [2*STEP_W-1:0] req_steps;
  logic [1:0]          req_ready;

  modport master (
    output req_valid,
    output req_dir,
    output req_par,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dir,
    input  req_par,
    input  req_steps,
    output req_ready
  );

endinterface

// File: rtl/counter_c_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer side wins when both request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/counter_c_sequencer.sv
// Sequences step commands from two requesters onto an enable-gated parity-stepping counter,
// keeping a shadow of the counter value and pulsing done at the end of each command.
module counter_c_sequencer
  import counter_c_pkg::*;
#(
  parameter int WIDTH  = counter_c_pkg::WIDTH,
  parameter int STEP_W = counter_c_pkg::STEP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  counter_c_sequencer_if.slave   req,
  input  logic                   abort,
  output logic                   cnt_f,
  output logic                   cnt_p,
  output logic                   cnt_en,
  output logic [WIDTH-1:0]       shadow_count,
  output logic                   busy,
  output logic                   done,
  output logic                   done_id,
  output logic                   done_aborted,
  output state_t                 fsm_state
);

  state_t            state;
  state_t            state_nxt;
  logic              ptr;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  logic              acc_id;
  logic [STEP_W-1:0] sel_steps;
  logic              dir_q;
  logic              par_q;
  logic              id_q;
  logic              aborted_q;
  logic [STEP_W-1:0] remaining;
  logic [WIDTH-1:0]  shadow;

  rr_arb2 u_arb (
    .req   (req.req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  assign acc_id    = grant[1];
  assign sel_steps = acc_id ? req.req_steps[STEP_W +: STEP_W] : req.req_steps[0 +: STEP_W];
  assign accept    = (state == IDLE) && (grant != 2'b00);

  always_comb begin
    state_nxt = state;
    ready     = 2'b00;
    cnt_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = grant;
        if (grant != 2'b00) begin
          state_nxt = (sel_steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = DONE;
        end else begin
          // Reset wins the same edge: the counter must not see a step while it is being cleared.
          cnt_en = !rst;
          if (remaining == STEP_W'(1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      dir_q     <= 1'b0;
      par_q     <= 1'b0;
      id_q      <= 1'b0;
      aborted_q <= 1'b0;
      remaining <= '0;
      shadow    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dir_q     <= req.req_dir[acc_id];
        par_q     <= req.req_par[acc_id];
        id_q      <= acc_id;
        aborted_q <= 1'b0;
        remaining <= sel_steps;
        ptr       <= ~acc_id;
      end else if (state == RUN) begin
        if (abort) begin
          aborted_q <= 1'b1;
        end else begin
          remaining <= remaining - STEP_W'(1);
          shadow    <= next_count(shadow, dir_q, par_q);
        end
      end
    end
  end

  assign req.req_ready  = ready;
  assign cnt_f          = dir_q;
  assign cnt_p          = par_q;
  assign shadow_count   = shadow;
  assign done_id        = done & id_q;
  assign done_aborted   = done & aborted_q;
  assign fsm_state      = state;

endmodule
